// File: rtl/keylock_pkg.sv
// rtl/keylock_pkg.sv - shared keylock constants, code type, engine state enum and key classifier
package keylock_pkg;
    localparam int CODE_DIGITS = 4;

    localparam logic [3:0] KEY_CANCEL = 4'd7;
    localparam logic [3:0] KEY_REPRO  = 4'd8;
    localparam logic [3:0] KEY_LOCK   = 4'd9;

    typedef logic [4*CODE_DIGITS-1:0] code_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_CONFIRM,
        ST_LOCKOUT
    } eng_state_t;

    function automatic logic is_cmd(input logic [3:0] key);
        return (key == KEY_CANCEL) || (key == KEY_REPRO) || (key == KEY_LOCK);
    endfunction
endpackage

// File: rtl/code_entry_engine_if.sv
// rtl/code_entry_engine_if.sv - keypad strobe, controller phase inputs and match qualifier outputs
interface code_entry_engine_if;
    logic       rdy;
    logic [3:0] keypress;
    logic       CheckPC;
    logic       CheckValidUC;
    logic       LOCKING;
    logic       Chillin;
    logic       matchPC;
    logic       matchUC;
    logic       ValidNewUC;
    logic [2:0] digit_count;
    logic       locked_out;

    modport master (
        output rdy, keypress, CheckPC, CheckValidUC, LOCKING, Chillin,
        input  matchPC, matchUC, ValidNewUC, digit_count, locked_out
    );

    modport slave (
        input  rdy, keypress, CheckPC, CheckValidUC, LOCKING, Chillin,
        output matchPC, matchUC, ValidNewUC, digit_count, locked_out
    );
endinterface

// File: rtl/lockout_timer.sv
// rtl/lockout_timer.sv - lockout down-counter; start loads CYCLES, busy while nonzero, last on final cycle
module lockout_timer #(
    parameter int CYCLES = 50_000_000
) (
    input  logic clk,
    input  logic resetN,
    input  logic i_start,
    output logic o_busy,
    output logic o_last
);
    localparam int W = $clog2(CYCLES + 1);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_cnt <= '0;
        end else if (i_start) begin
            r_cnt <= W'(CYCLES);
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign o_busy = (r_cnt != '0);
    assign o_last = (r_cnt == W'(1));
endmodule

// File: rtl/code_entry_engine.sv
// rtl/code_entry_engine.sv - keypad entry buffer, user-code store, match qualifiers; lockout under KEYLOCK_LOCKOUT_EN
module code_entry_engine #(
    parameter int                       CODE_DIGITS    = 4,
    parameter logic [4*CODE_DIGITS-1:0] PC_VALUE       = 16'h1234,
    parameter logic [4*CODE_DIGITS-1:0] UC_RESET       = 16'h0000,
    parameter int                       LOCKOUT_CYCLES = 50_000_000
) (
    input  logic               clk,
    input  logic               resetN,
    code_entry_engine_if.slave bus
);
    import keylock_pkg::*;

    localparam logic [2:0] FULL_CNT = 3'(CODE_DIGITS);
    localparam logic [2:0] SAT_CNT  = 3'(CODE_DIGITS + 1);

    typedef logic [4*CODE_DIGITS-1:0] word_t;

    word_t      r_buf;
    word_t      r_cand;
    word_t      r_uc;
    logic [2:0] r_count;
    logic       r_chillin_d;
    eng_state_t r_state;
    eng_state_t w_next;

    logic w_active, w_key, w_digit, w_enter, w_lock_blk, w_full, w_cand_valid;
    logic w_match_pc, w_match_uc, w_valid_new, w_accept, w_cancel, w_commit;

    assign w_active = bus.CheckPC | bus.CheckValidUC | bus.LOCKING;
    assign w_key    = bus.rdy & w_active;
    assign w_enter  = w_key & is_cmd(bus.keypress);
    assign w_digit  = w_key & ~is_cmd(bus.keypress) & ~w_lock_blk;

    // Every qualifier depends on registered state only; the controller samples them in the enter-key cycle.
    assign w_full       = (r_count == FULL_CNT) & ~w_lock_blk;
    assign w_cand_valid = (r_state == ST_CONFIRM);
    assign w_match_pc   = w_full & (r_buf == PC_VALUE);
    assign w_match_uc   = w_full & (r_buf == r_uc);
    assign w_valid_new  = w_full & (~w_cand_valid | (r_buf == r_cand));

    assign w_accept = w_enter & (bus.keypress == KEY_REPRO) & bus.CheckValidUC
                    & w_valid_new & (r_state == ST_COLLECT);
    assign w_cancel = w_enter & (bus.keypress == KEY_CANCEL) & bus.CheckValidUC;
    assign w_commit = bus.Chillin & ~r_chillin_d & w_cand_valid;

`ifdef KEYLOCK_LOCKOUT_EN
    logic [1:0] r_fails;
    logic       w_fail, w_success, w_trip, w_timer_busy, w_timer_last;

    assign w_fail = w_enter & (r_state != ST_LOCKOUT)
                  & (((bus.keypress == KEY_LOCK) & bus.LOCKING & ~w_match_uc)
                   | ((bus.keypress == KEY_REPRO) & bus.CheckPC & ~w_match_pc));
    assign w_success = w_enter
                  & (((bus.keypress == KEY_LOCK) & bus.LOCKING & w_match_uc)
                   | ((bus.keypress == KEY_REPRO) & bus.CheckPC & w_match_pc));
    assign w_trip = w_fail & (r_fails == 2'd2);

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_fails <= 2'd0;
        end else if (w_trip || w_success) begin
            r_fails <= 2'd0;
        end else if (w_fail) begin
            r_fails <= r_fails + 2'd1;
        end
    end

    lockout_timer #(.CYCLES(LOCKOUT_CYCLES)) u_lockout_timer (
        .clk     (clk),
        .resetN  (resetN),
        .i_start (w_trip),
        .o_busy  (w_timer_busy),
        .o_last  (w_timer_last)
    );

    assign w_lock_blk = (r_state == ST_LOCKOUT) & w_timer_busy;
`else
    logic w_unused_lockout_cfg;
    assign w_unused_lockout_cfg = (LOCKOUT_CYCLES != 0);
    assign w_lock_blk = 1'b0;
`endif

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:    if (w_active) w_next = ST_COLLECT;
            ST_COLLECT: begin
                if (!w_active)     w_next = ST_IDLE;
                else if (w_accept) w_next = ST_CONFIRM;
            end
            ST_CONFIRM: begin
                if (!w_active || w_commit) w_next = ST_IDLE;
                else if (w_cancel)         w_next = ST_COLLECT;
            end
`ifdef KEYLOCK_LOCKOUT_EN
            ST_LOCKOUT: if (w_timer_last || !w_timer_busy) w_next = ST_IDLE;
`endif
            default:    w_next = ST_IDLE;
        endcase
`ifdef KEYLOCK_LOCKOUT_EN
        if (w_trip) w_next = ST_LOCKOUT;
`endif
    end

    // Commit samples the candidate flag before the same edge drops it on leaving CONFIRM.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_buf       <= '0;
            r_count     <= 3'd0;
            r_cand      <= '0;
            r_uc        <= UC_RESET;
            r_chillin_d <= 1'b0;
        end else begin
            r_chillin_d <= bus.Chillin;
            if (!w_active || w_enter) begin
                r_buf   <= '0;
                r_count <= 3'd0;
            end else if (w_digit && (r_count != SAT_CNT)) begin
                r_buf   <= {r_buf[4*CODE_DIGITS-5:0], bus.keypress};
                r_count <= r_count + 3'd1;
            end
            if (w_accept) r_cand <= r_buf;
            if (w_commit) r_uc   <= r_cand;
        end
    end

    assign bus.matchPC     = w_match_pc;
    assign bus.matchUC     = w_match_uc;
    assign bus.ValidNewUC  = w_valid_new;
    assign bus.digit_count = r_count;
    assign bus.locked_out  = w_lock_blk;
endmodule

// File: tb/tb_code_entry_engine.sv
// tb/tb_code_entry_engine.sv - directed self-checking bench for code_entry_engine (lockout steps with KEYLOCK_LOCKOUT_EN)
module tb_code_entry_engine;
    logic clk = 1'b0;
    logic resetN = 1'b0;
    int   checks = 0;
    int   failures = 0;

    code_entry_engine_if bus();

    code_entry_engine #(
        .CODE_DIGITS    (4),
        .PC_VALUE       (16'h1234),
        .UC_RESET       (16'h0000),
        .LOCKOUT_CYCLES (10)
    ) dut (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic begin_key(input logic [3:0] k);
        bus.rdy = 1'b1;
        bus.keypress = k;
        #1;
    endtask

    task automatic end_key();
        @(negedge clk);
        bus.rdy = 1'b0;
    endtask

    task automatic key(input logic [3:0] k);
        begin_key(k);
        end_key();
    endtask

    task automatic digits(input logic [15:0] code);
        for (int i = 3; i >= 0; i--) key(code[4*i +: 4]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        bus.rdy = 0; bus.keypress = 0; bus.CheckPC = 0; bus.CheckValidUC = 0;
        bus.LOCKING = 0; bus.Chillin = 0;
        @(negedge clk); @(negedge clk);
        chk("rst_count", 16'(bus.digit_count), 16'd0);
        chk("rst_matchUC", 16'(bus.matchUC), 16'd0);
        chk("rst_matchPC", 16'(bus.matchPC), 16'd0);
        chk("rst_validnew", 16'(bus.ValidNewUC), 16'd0);
        chk("rst_locked", 16'(bus.locked_out), 16'd0);
        resetN = 1'b1;
        @(negedge clk);

        // unlock with reset user code 0000
        bus.LOCKING = 1;
        digits(16'h0000);
        chk("unlock_count4", 16'(bus.digit_count), 16'd4);
        begin_key(4'd9);
        chk("unlock_matchUC", 16'(bus.matchUC), 16'd1);
        chk("unlock_matchPC", 16'(bus.matchPC), 16'd0);
        end_key();
        chk("unlock_count_clr", 16'(bus.digit_count), 16'd0);
        chk("unlock_match_clr", 16'(bus.matchUC), 16'd0);
        bus.LOCKING = 0;
        @(negedge clk);

        // programmer code
        bus.CheckPC = 1;
        digits(16'h1234);
        begin_key(4'd8);
        chk("pc_match", 16'(bus.matchPC), 16'd1);
        chk("pc_matchUC", 16'(bus.matchUC), 16'd0);
        end_key();
        digits(16'h1235);
        begin_key(4'd8);
        chk("pc_wrong", 16'(bus.matchPC), 16'd0);
        end_key();
        bus.CheckPC = 0;
        @(negedge clk);

        // new code 456A, two entries then commit
        bus.CheckValidUC = 1;
        digits(16'h456A);
        begin_key(4'd8);
        chk("new_first_valid", 16'(bus.ValidNewUC), 16'd1);
        end_key();
        chk("new_after_repro", 16'(bus.ValidNewUC), 16'd0);
        key(4'h4); key(4'h5); key(4'h6);
        chk("new_three_digits", 16'(bus.ValidNewUC), 16'd0);
        key(4'hA);
        chk("new_confirm_valid", 16'(bus.ValidNewUC), 16'd1);
        key(4'd8);
        bus.CheckValidUC = 0;
        bus.Chillin = 1;
        @(negedge clk);
        bus.Chillin = 0;
        bus.LOCKING = 1;
        digits(16'h456A);
        chk("uc_new_match", 16'(bus.matchUC), 16'd1);
        key(4'd7);
        digits(16'h0000);
        chk("uc_old_gone", 16'(bus.matchUC), 16'd0);
        key(4'd7);
        bus.LOCKING = 0;
        @(negedge clk);

        // mismatched confirm; controller leaves new-code phase before Chillin
        bus.CheckValidUC = 1;
        digits(16'h1111);
        key(4'd8);
        digits(16'h1112);
        chk("mismatch_valid", 16'(bus.ValidNewUC), 16'd0);
        key(4'd8);
        bus.CheckValidUC = 0;
        @(negedge clk);
        bus.Chillin = 1;
        @(negedge clk);
        bus.Chillin = 0;
        bus.LOCKING = 1;
        digits(16'h456A);
        chk("mismatch_uc_kept", 16'(bus.matchUC), 16'd1);
        key(4'd7);
        digits(16'h1111);
        chk("mismatch_no_commit", 16'(bus.matchUC), 16'd0);
        key(4'd7);

        // too-long entry
        digits(16'h456A);
        key(4'h4);
        chk("long_count5", 16'(bus.digit_count), 16'd5);
        chk("long_matchUC", 16'(bus.matchUC), 16'd0);
        key(4'h5);
        chk("long_saturate", 16'(bus.digit_count), 16'd5);
        key(4'd7);
        chk("long_cancel", 16'(bus.digit_count), 16'd0);
        bus.LOCKING = 0;
        @(negedge clk);

        // inactive keys ignored
        key(4'd9); key(4'h3);
        chk("inactive_count", 16'(bus.digit_count), 16'd0);

        // reset mid-entry drops candidate and restores UC_RESET
        bus.CheckValidUC = 1;
        digits(16'h2222);
        key(4'd8);
        key(4'h2);
        resetN = 1'b0;
        #1;
        chk("rst_async_count", 16'(bus.digit_count), 16'd0);
        @(negedge clk);
        resetN = 1'b1;
        bus.CheckValidUC = 0;
        bus.Chillin = 1;
        @(negedge clk);
        bus.Chillin = 0;
        bus.LOCKING = 1;
        digits(16'h0000);
        chk("rst_uc_restored", 16'(bus.matchUC), 16'd1);
        key(4'd9);
        digits(16'h2222);
        chk("rst_no_commit", 16'(bus.matchUC), 16'd0);
        key(4'd7);
        chk("default_locked", 16'(bus.locked_out), 16'd0);

`ifdef KEYLOCK_LOCKOUT_EN
        // three wrong LOCK_ENTERs -> 10-cycle lockout
        for (int n = 0; n < 3; n++) begin
            digits(16'h1111);
            key(4'd9);
        end
        for (int c = 0; c < 10; c++) begin
            chk("lockout_active", 16'(bus.locked_out), 16'd1);
            chk("lockout_no_digits", 16'(bus.digit_count), 16'd0);
            key(4'h1);
        end
        chk("lockout_end", 16'(bus.locked_out), 16'd0);
        digits(16'h0000);
        chk("lockout_exit_match", 16'(bus.matchUC), 16'd1);
        key(4'd9);
        for (int n = 0; n < 3; n++) begin
            digits(16'h1111);
            key(4'd9);
        end
        chk("lockout_again", 16'(bus.locked_out), 16'd1);
        @(negedge clk); @(negedge clk);
        resetN = 1'b0;
        #1;
        chk("lockout_reset", 16'(bus.locked_out), 16'd0);
        @(negedge clk);
        resetN = 1'b1;
`endif
        bus.LOCKING = 0;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/code_entry_engine.md
# code_entry_engine

Keypad code-entry datapath sequencer for the keylock. It collects digit keypresses into an entry buffer and holds the stored user code (UC). It generates the `matchPC`, `matchUC` and `ValidNewUC` qualifiers consumed by the lock controller FSM. It sequences the two-entry new-code capture and commits the new UC when the controller reaches its success state.

## Interface
Parameters:
- `CODE_DIGITS`, 4: digits per code, 4 bits each.
- `PC_VALUE`, 16'h1234: fixed programmer code; width `4*CODE_DIGITS`.
- `UC_RESET`, 16'h0000: user code after reset.
- `LOCKOUT_CYCLES`, 50_000_000: lockout duration in clocks; used only with `KEYLOCK_LOCKOUT_EN`.

Ports:
- `clk`  in  1: clock.
- `resetN`  in  1: reset, asynchronous, active-low.
- `rdy`  in  1: keypress valid strobe; one cycle per key.
- `keypress`  in  4: key code, sampled when `rdy`=1.
- `CheckPC`  in  1: controller is in the programmer-code phase.
- `CheckValidUC`  in  1: controller is in a new-code entry phase.
- `LOCKING`  in  1: controller is in the lock/unlock entry phase.
- `Chillin`  in  1: controller is in the success state; its rising edge commits the new code.
- `matchPC`  out  1: buffer holds exactly `CODE_DIGITS` digits and equals `PC_VALUE`.
- `matchUC`  out  1: buffer holds exactly `CODE_DIGITS` digits and equals the stored UC.
- `ValidNewUC`  out  1: the new-code entry is acceptable (see Operation).
- `digit_count`  out  3: number of digits in the buffer; saturates at `CODE_DIGITS+1`.
- `locked_out`  out  1: lockout active; always 0 without the macro.

## Operation
- Key classes: 7 = CANCEL, 8 = REPRO_ENTER, 9 = LOCK_ENTER, every other value = DIGIT.
- Entry is "active" when `CheckPC | CheckValidUC | LOCKING`. While inactive, the buffer, `digit_count` and the candidate-valid flag are cleared every cycle.
- DIGIT while active:
  - The buffer shifts left by 4 and the new digit enters the low nibble.
  - `digit_count` increments and saturates at `CODE_DIGITS+1`.
  - At the saturation count the buffer contents are frozen and all match outputs are 0 (too-long entry).
- CANCEL, REPRO_ENTER or LOCK_ENTER: the buffer and `digit_count` clear at the next edge. The outputs seen in the strobe cycle are the pre-clear values; the controller samples them in that cycle.
- New-code sequence, while `CheckValidUC`=1:
  - First entry: `cand_valid`=0. `ValidNewUC` = (`digit_count`==`CODE_DIGITS`).
  - REPRO_ENTER with `ValidNewUC`=1 copies the buffer into `cand` and sets `cand_valid`.
  - Second entry: `cand_valid`=1. `ValidNewUC` = (count==`CODE_DIGITS`) & (buffer==`cand`).
  - CANCEL clears `cand_valid`.
- Commit: on a `Chillin` rising edge with `cand_valid`=1, the stored UC takes the value of `cand` and `cand_valid` clears. Commit never happens otherwise.
- Internal FSM states:
  - IDLE: entry inactive.
  - COLLECT: entry active, `cand_valid`=0.
  - CONFIRM: `cand_valid`=1.
  - LOCKOUT: macro builds only.
  - Transitions: IDLE→COLLECT when entry becomes active. COLLECT→CONFIRM on accepted first REPRO_ENTER. CONFIRM→IDLE on commit or when entry goes inactive. Any state→IDLE when entry goes inactive, except LOCKOUT, which runs to completion.
- Reset values: buffer 0, `cand` 0, stored UC = `UC_RESET`, `digit_count` 0, all outputs 0, FSM IDLE. Reset asserted mid-entry discards the entry and any uncommitted candidate.

## Timing
- Match and valid outputs are combinational from registered state only, with no input-to-output paths. They are valid in the cycle after the last digit's `rdy`.
- Back-to-back `rdy` on consecutive cycles is supported: DIGIT at cycle t followed by an enter key at t+1 sees the updated buffer.
- `rdy` asserted with a non-digit key while entry is inactive is ignored.
- Commit latency: UC updates at the first edge after `Chillin` rises. `matchUC` reflects the new UC from the following cycle.

## Configuration
- `KEYLOCK_LOCKOUT_EN` defined:
  - A 2-bit fail counter increments on LOCK_ENTER in `LOCKING` with `matchUC`=0, and on REPRO_ENTER in `CheckPC` with `matchPC`=0.
  - Any successful match on enter clears the counter.
  - The third failure enters LOCKOUT for `LOCKOUT_CYCLES` clocks. During LOCKOUT, `locked_out`=1, digits are ignored, all match outputs are 0, and the counter is 0 on exit.
  - Reset clears the counter and aborts the lockout.
- Macro undefined: no counter or timer logic; `locked_out` is tied to 0.

## Structure
- Shared package `keylock_pkg`:
  - constants `KEY_CANCEL`=7, `KEY_REPRO`=8, `KEY_LOCK`=9;
  - `CODE_DIGITS`;
  - `code_t` (logic [4*CODE_DIGITS-1:0]);
  - the engine state enum.
- One sub-module, `lockout_timer`: down-counter with start/busy. It is instantiated only under `KEYLOCK_LOCKOUT_EN`.

## Test plan
- Unlock path: `LOCKING`=1, digits 0,0,0,0 then key 9 → `matchUC`=1 in the key-9 cycle; `digit_count`=0 the cycle after.
- Programmer code: `CheckPC`=1, digits 1,2,3,4 then key 8 → `matchPC`=1. Digits 1,2,3,5 → `matchPC`=0.
- New code:
  - `CheckValidUC`=1, enter 4,5,6,A then key 8 → candidate captured.
  - Re-enter 4,5,6,A → `ValidNewUC`=1.
  - `Chillin` pulse → UC=16'h456A.
  - Later, `LOCKING` with 4,5,6,A → `matchUC`=1.
- Mismatched confirm: first entry 1,1,1,1, second entry 1,1,1,2 → `ValidNewUC`=0. A `Chillin` pulse leaves UC unchanged.
- Too long: 5 digits in `LOCKING` → `digit_count`=5 and `matchUC`=0. CANCEL → count 0.
- Lockout (macro on, `LOCKOUT_CYCLES`=10): three wrong LOCK_ENTERs → `locked_out`=1 for exactly 10 cycles and digits are ignored. `resetN` low mid-lockout → `locked_out`=0 immediately.
